// File: rtl/stream_mux_nto1_if.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_nto1_if
//  Purpose  : Bundles the valid/ready producer side (N_CH channels) and the
//             single consumer side of the N-to-1 stream multiplexer, plus its
//             mode/select controls.
//  Ports    : (interface signals)
//             mode       0 = fixed select, 1 = round-robin
//             sel        channel passed in fixed mode
//             in_data    channel i data at [i*W +: W]
//             in_valid   per-channel valid
//             in_ready   per-channel ready (at most one bit set)
//             out_data   registered output word
//             out_valid  output register holds a word
//             out_ready  consumer accepts out_data this cycle
//             out_ch     source channel of out_data
//  Modports : master - environment (producers, consumer, control)
//             slave  - the multiplexer
//  Revision : 1.0 - initial release
// ============================================================================
interface stream_mux_nto1_if #(
   parameter int N_CH = 4,
   parameter int W    = 8
);
   localparam int SEL_W = $clog2(N_CH);

   logic                 mode;
   logic [SEL_W-1:0]     sel;
   logic [N_CH*W-1:0]    in_data;
   logic [N_CH-1:0]      in_valid;
   logic [N_CH-1:0]      in_ready;
   logic [W-1:0]         out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [SEL_W-1:0]     out_ch;

   modport master (
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_ch
   );

   modport slave (
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_ch
   );
endinterface
`default_nettype wire

// File: rtl/stream_mux_nto1.sv
`default_nettype none
// ============================================================================
//  Module   : stream_mux_nto1
//  Purpose  : N-to-1 W-bit stream multiplexer with valid/ready handshake and a
//             registered output stage. Fixed-select or round-robin grant; at
//             most one word accepted per cycle.
//  Ports    : clk     - clock, all state on rising edge
//             resetn  - asynchronous active-low reset
//             bus     - stream_mux_nto1_if.slave (controls, N input channels,
//                       one registered output channel)
//  Revision : 1.0 - initial release
// ============================================================================
module stream_mux_nto1 #(
   parameter int N_CH = 4,
   parameter int W    = 8
) (
   input  logic                   clk,
   input  logic                   resetn,
   stream_mux_nto1_if.slave       bus
);
   localparam int SEL_W = $clog2(N_CH);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [W-1:0]      r_out_data;
   logic              r_out_valid;
   logic [SEL_W-1:0]  r_out_ch;
   logic [SEL_W-1:0]  r_rr_ptr;

   // ---------------------------------------------------------------------
   // Combinational grant
   // ---------------------------------------------------------------------
   logic              w_slot_free;
   logic              w_gnt_vld;
   logic [SEL_W-1:0]  w_gnt;
   logic [W-1:0]      w_word;
   logic [N_CH-1:0]   w_in_ready;
   logic              w_xfer_in;

   // Output register may be loaded while its current word is being drained.
   assign w_slot_free = !r_out_valid || bus.out_ready;

   always_comb begin : p_grant
      int v_idx;
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      v_idx     = 0;
      if (!bus.mode) begin
         // An out-of-range sel matches no channel, so nothing is granted.
         for (int i = 0; i < N_CH; i++) begin
            if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
               w_gnt_vld = 1'b1;
               w_gnt     = SEL_W'(i);
            end
         end
      end else begin
         // Search starts at the pointer and wraps; first valid channel wins.
         for (int k = 0; k < N_CH; k++) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= N_CH) begin
               v_idx = v_idx - N_CH;
            end
            if (!w_gnt_vld && bus.in_valid[v_idx]) begin
               w_gnt_vld = 1'b1;
               w_gnt     = SEL_W'(v_idx);
            end
         end
      end
   end

   always_comb begin : p_word_mux
      w_word = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (w_gnt == SEL_W'(i)) begin
            w_word = bus.in_data[i*W +: W];
         end
      end
   end

   // Ready is held low throughout reset regardless of the other inputs.
   always_comb begin : p_ready
      w_in_ready = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_in_ready[i] = resetn && w_gnt_vld && w_slot_free && (w_gnt == SEL_W'(i));
      end
   end

   // A grant implies in_valid of that channel, so ready on it means a transfer.
   assign w_xfer_in = w_gnt_vld && w_slot_free;

   // ---------------------------------------------------------------------
   // Output register and round-robin pointer
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_rr_ptr    <= '0;
      end else begin
         if (w_xfer_in) begin
            r_out_data  <= w_word;
            r_out_ch    <= w_gnt;
            r_out_valid <= 1'b1;
            if (bus.mode) begin
               r_rr_ptr <= (w_gnt == SEL_W'(N_CH - 1)) ? '0 : (w_gnt + SEL_W'(1));
            end
         end else if (bus.out_ready) begin
            // Drained with nothing to replace it; data/channel keep last value.
            r_out_valid <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_data  = r_out_data;
   assign bus.out_valid = r_out_valid;
   assign bus.out_ch    = r_out_ch;

endmodule
`default_nettype wire
